// File: rtl/fifo_pkg.sv
// Shared FIFO pointer definitions: side modes, default width, and
// the Gray/binary conversion functions used by RTL and testbench alike.
package fifo_pkg;

    localparam int MODE_WRITE     = 0;
    localparam int MODE_READ      = 1;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int PTR_W_MAX      = 17;

    typedef logic [PTR_W_MAX-1:0] ptr_t;

    function automatic ptr_t ptr_mask(input int width);
        return (ptr_t'(1) << width) - ptr_t'(1);
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b, input int width);
        return ((b >> 1) ^ b) & ptr_mask(width);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g, input int width);
        ptr_t gm;
        ptr_t b;
        gm = g & ptr_mask(width);
        b  = gm;
        for (int s = 1; s < PTR_W_MAX; s++) begin
            b = b ^ (gm >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_ptr_ctrl_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR
// of all Gray bits at or above its position.
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_ptr_ctrl.sv
// One side of an async FIFO: binary/Gray pointer pair plus registered
// full/empty, occupancy level and almost flag against the remote pointer.
module gray_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int MODE       = MODE_WRITE,
    parameter int ALMOST_TH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    input  logic [ADDR_WIDTH:0]   sync_gray,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH:0]   ptr_bin,
    output logic [ADDR_WIDTH:0]   ptr_gray,
    output logic                  flag,
    output logic                  almost,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int AW    = ADDR_WIDTH;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    localparam logic FLAG_RST   = (MODE == MODE_READ);
    localparam logic ALMOST_RST = (MODE == MODE_READ) ||
                                  (ALMOST_TH == DEPTH);

    logic          adv;
    logic [AW:0]   sync_bin;
    logic [AW:0]   bin_nxt;
    logic [AW:0]   gray_nxt;
    logic [AW:0]   level_nxt;
    logic          flag_nxt;
    logic          almost_nxt;

    gray2bin #(
        .WIDTH(PW)
    ) u_sync_g2b (
        .gray(sync_gray),
        .bin (sync_bin)
    );

    assign adv      = inc & ~flag;
    assign bin_nxt  = ptr_bin + PW'(adv);
    assign gray_nxt = (bin_nxt >> 1) ^ bin_nxt;
    assign addr     = ptr_bin[AW-1:0];

    if (MODE == MODE_WRITE) begin : g_wr
        // Full when the remote pointer is one lap behind: top two Gray bits differ
        localparam logic [AW:0] FULL_MASK = PW'(3) << (AW - 1);
        localparam logic [AW:0] ALM_TH    = PW'(DEPTH - ALMOST_TH);

        assign flag_nxt   = (gray_nxt == (sync_gray ^ FULL_MASK));
        assign level_nxt  = bin_nxt - sync_bin;
        assign almost_nxt = (level_nxt >= ALM_TH);
    end else begin : g_rd
        localparam logic [AW:0] ALM_TH = PW'(ALMOST_TH);

        assign flag_nxt   = (gray_nxt == sync_gray);
        assign level_nxt  = sync_bin - bin_nxt;
        assign almost_nxt = (level_nxt <= ALM_TH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_bin  <= '0;
            ptr_gray <= '0;
            level    <= '0;
            flag     <= FLAG_RST;
            almost   <= ALMOST_RST;
        end else begin
            ptr_bin  <= bin_nxt;
            ptr_gray <= gray_nxt;
            level    <= level_nxt;
            flag     <= flag_nxt;
            almost   <= almost_nxt;
        end
    end

endmodule
